// File: rtl/arm_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory request/response, branch redirect
// and the decode-facing instruction output channel.
interface arm_fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;

  modport master (
    output imem_req_valid, imem_req_addr, out_valid, out_inst, out_pc,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
           redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, out_valid, out_inst, out_pc,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
           redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/arm_fetch_unit.sv
// Instruction fetch stage: credit-limited word fetches, in-order response
// capture into a prefetch queue, and redirect flush of the stale stream.
module arm_fetch_unit #(
  parameter int unsigned QUEUE_DEPTH = 4,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
  input  logic                          clk,
  input  logic                          reset,
  arm_fetch_unit_if.master              fetch_if,
  output logic [$clog2(QUEUE_DEPTH):0]  occupancy
);
  localparam int unsigned AW = $clog2(QUEUE_DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  typedef enum logic {
    MODE_RUN   = 1'b0,
    MODE_FLUSH = 1'b1
  } mode_e;

  entry_t        queue_q [QUEUE_DEPTH];
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] discard_q, discard_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  mode_e         mode_q, mode_d;

  logic          flushing_c;
  logic          req_valid_c, req_fire, resp_fire, redirect, push, pop;
  logic [CW:0]   credit_used;
  logic [31:0]   redirect_aligned;

  // Credit rule: outstanding requests plus queued words never exceed the queue size
  assign credit_used      = (CW+1)'(inflight_q) + (CW+1)'(count_q);
  assign req_valid_c      = !reset && (credit_used < (CW+1)'(QUEUE_DEPTH));
  assign req_fire         = req_valid_c && fetch_if.imem_req_ready;
  assign resp_fire        = !reset && fetch_if.imem_resp_valid;
  assign redirect         = !reset && fetch_if.redirect_valid;
  assign redirect_aligned = fetch_if.redirect_pc & ~32'h0000_0003;

  // A response in the redirect cycle always belongs to the old stream
  assign push = resp_fire && !redirect && !flushing_c;
  assign pop  = fetch_if.out_valid && fetch_if.out_ready && !redirect;

  assign fetch_if.imem_req_valid = req_valid_c;
  assign fetch_if.imem_req_addr  = fetch_pc_q;
  assign fetch_if.out_valid      = !reset && (count_q != '0);
  assign fetch_if.out_inst       = queue_q[head_q].inst;
  assign fetch_if.out_pc         = queue_q[head_q].pc;
  assign occupancy               = count_q;

  always_comb begin
    inflight_d = inflight_q + CW'(req_fire) - CW'(resp_fire);
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    discard_d  = discard_q;
    count_d    = count_q;
    head_d     = head_q;
    tail_d     = tail_q;
    if (redirect) begin
      fetch_pc_d = redirect_aligned;
      resp_pc_d  = redirect_aligned;
      discard_d  = inflight_d;
      count_d    = '0;
      head_d     = tail_q;
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (resp_fire && (discard_q != '0)) begin
        discard_d = discard_q - CW'(1);
      end
      if (push) begin
        resp_pc_d = resp_pc_q + 32'd4;
        tail_d    = tail_q + AW'(1);
      end
      if (pop) begin
        head_d = head_q + AW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      inflight_q <= '0;
      discard_q  <= '0;
      count_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
      count_q    <= count_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      queue_q[tail_q] <= '{pc: resp_pc_q, inst: fetch_if.imem_resp_data};
    end
  end

  // Mode FSM: state register
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q <= MODE_RUN;
    end else begin
      mode_q <= mode_d;
    end
  end

  // Mode FSM: flush while stale responses remain outstanding
  always_comb begin
    mode_d = MODE_RUN;
    if (discard_d != '0) begin
      mode_d = MODE_FLUSH;
    end
  end

  // Mode FSM: output decode
  always_comb begin
    flushing_c = 1'b0;
    if (mode_q == MODE_FLUSH) begin
      flushing_c = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(fetch_if.imem_resp_valid && (inflight_q == '0)))
        else $error("arm_fetch_unit: imem response with no request outstanding");
    end
  end
endmodule

// File: tb/tb_arm_fetch_unit.sv
// Directed plus randomized bench for arm_fetch_unit with a variable-latency
// in-order memory model and an output scoreboard.
module tb_arm_fetch_unit;
  localparam int unsigned DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  typedef struct {
    logic [31:0] addr;
    int          due;
    int          epoch;
  } mreq_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } sb_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  occupancy;

  arm_fetch_unit_if bus ();

  arm_fetch_unit #(.QUEUE_DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .clk       (clk),
    .reset     (reset),
    .fetch_if  (bus),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  mreq_t       pend[$];
  sb_t         sb[$];
  int          cyc     = 0;
  int          epoch   = 0;
  int          mem_lat = 1;
  int          checks  = 0;
  int          errors  = 0;
  int          n_req   = 0;
  int          n_pop   = 0;
  int          pops0;
  logic [31:0] exp_req = RST_PC;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // In-order memory: front request answered once its latency has elapsed
  initial begin
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = '0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (pend.size() != 0 && pend[0].due <= cyc) begin
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_data  = memf(pend[0].addr);
      end else begin
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = '0;
      end
    end
  end

  // Handshake monitor: request address model, response filtering, output scoreboard
  always @(negedge clk) begin : monitor
    mreq_t r;
    sb_t   e;
    if (reset) begin
      pend.delete();
      sb.delete();
      epoch++;
      exp_req = RST_PC;
      n_req   = 0;
      n_pop   = 0;
    end else begin
      if (bus.out_valid && bus.out_ready && !bus.redirect_valid) begin
        n_pop++;
        chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("out_pc", bus.out_pc, e.pc);
          chk("out_inst", bus.out_inst, e.inst);
        end
      end
      if (bus.imem_resp_valid && pend.size() != 0) begin
        r = pend.pop_front();
        if (!bus.redirect_valid && r.epoch == epoch) begin
          e.pc   = r.addr;
          e.inst = memf(r.addr);
          sb.push_back(e);
        end
      end
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        chk("req_addr", bus.imem_req_addr, exp_req);
        r.addr  = bus.imem_req_addr;
        r.due   = cyc + mem_lat;
        r.epoch = epoch;
        pend.push_back(r);
        exp_req = exp_req + 32'd4;
        n_req++;
      end
      if (bus.redirect_valid) begin
        epoch++;
        sb.delete();
        exp_req = bus.redirect_pc & ~32'h0000_0003;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset              = 1'b1;
    bus.imem_req_ready = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.out_ready      = 1'b1;
    mem_lat            = 1;

    // Zero-wait memory streaming
    next_cycle();
    @(negedge clk);
    chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_occupancy", 32'(occupancy), 32'd0);
    chk("first_req_valid", 32'(bus.imem_req_valid), 32'd1);
    chk("first_req_addr", bus.imem_req_addr, RST_PC);
    next_cycle();
    @(negedge clk);
    chk("fill_out_valid", 32'(bus.out_valid), 32'd0);
    for (int k = 0; k < 7; k++) begin
      next_cycle();
      @(negedge clk);
      chk("stream_valid", 32'(bus.out_valid), 32'd1);
      chk("stream_pc", bus.out_pc, 32'(k * 4));
      chk("stream_inst", bus.out_inst, memf(32'(k * 4)));
    end

    // Back-pressure fills the queue and stops issue
    next_cycle();
    mem_lat       = 3;
    bus.out_ready = 1'b0;
    reset         = 1'b1;
    next_cycle();
    reset = 1'b0;
    repeat (10) next_cycle();
    @(negedge clk);
    chk("full_occupancy", 32'(occupancy), 32'd4);
    chk("full_req_valid", 32'(bus.imem_req_valid), 32'd0);
    next_cycle();
    chk("full_req_count", 32'(n_req), 32'd4);
    repeat (3) next_cycle();
    @(negedge clk);
    chk("hold_occupancy", 32'(occupancy), 32'd4);
    next_cycle();
    bus.out_ready = 1'b1;
    pops0         = n_pop;
    repeat (30) next_cycle();
    chk("resume_progress", 32'((n_pop - pops0) >= 12), 32'd1);

    // Redirect with three stale requests in flight
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    next_cycle();
    next_cycle();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0100;
    @(negedge clk);
    chk("stale3_req_valid", 32'(bus.imem_req_valid), 32'd1);
    next_cycle();
    bus.redirect_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
      next_cycle();
    end
    @(negedge clk);
    chk("target_valid", 32'(bus.out_valid), 32'd1);
    chk("target_pc", bus.out_pc, 32'h0000_0100);
    chk("target_inst", bus.out_inst, memf(32'h0000_0100));

    // Redirect coinciding with response, request and output handshakes
    next_cycle();
    mem_lat = 1;
    reset   = 1'b1;
    next_cycle();
    reset = 1'b0;
    repeat (5) next_cycle();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0200;
    @(negedge clk);
    chk("coinc_resp", 32'(bus.imem_resp_valid), 32'd1);
    chk("coinc_req", 32'(bus.imem_req_valid), 32'd1);
    chk("coinc_out", 32'(bus.out_valid), 32'd1);
    next_cycle();
    bus.redirect_valid = 1'b0;
    @(negedge clk);
    chk("coinc_flush_valid", 32'(bus.out_valid), 32'd0);
    chk("coinc_flush_occ", 32'(occupancy), 32'd0);
    next_cycle();
    @(negedge clk);
    chk("coinc_drop_valid", 32'(bus.out_valid), 32'd0);
    next_cycle();
    @(negedge clk);
    chk("coinc_target_valid", 32'(bus.out_valid), 32'd1);
    chk("coinc_target_pc", bus.out_pc, 32'h0000_0200);

    // Misaligned redirect near the top of the address space wraps to zero
    next_cycle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    repeat (3) next_cycle();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFE;
    next_cycle();
    bus.redirect_valid = 1'b0;
    @(negedge clk);
    chk("wrap_req_addr0", bus.imem_req_addr, 32'hFFFF_FFFC);
    next_cycle();
    @(negedge clk);
    chk("wrap_req_addr1", bus.imem_req_addr, 32'h0000_0000);
    next_cycle();
    @(negedge clk);
    chk("wrap_out_pc0", bus.out_pc, 32'hFFFF_FFFC);
    next_cycle();
    @(negedge clk);
    chk("wrap_out_pc1", bus.out_pc, 32'h0000_0000);

    // Mid-stream reset with words queued and a request outstanding
    next_cycle();
    mem_lat       = 3;
    bus.out_ready = 1'b0;
    reset         = 1'b1;
    next_cycle();
    reset = 1'b0;
    repeat (6) next_cycle();
    @(negedge clk);
    chk("pre_reset_occ", 32'(occupancy), 32'd3);
    next_cycle();
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("post_rst_occ", 32'(occupancy), 32'd0);
    chk("post_rst_req_addr", bus.imem_req_addr, RST_PC);
    next_cycle();
    bus.out_ready = 1'b1;
    repeat (10) next_cycle();

    // Randomized back-pressure and redirects
    mem_lat = 2;
    for (int k = 0; k < 400; k++) begin
      bus.imem_req_ready = ($urandom_range(3) != 0);
      bus.out_ready      = ($urandom_range(2) != 0);
      bus.redirect_valid = ($urandom_range(19) == 0);
      bus.redirect_pc    = $urandom & 32'h0000_FFFF;
      next_cycle();
    end
    bus.redirect_valid = 1'b0;
    bus.imem_req_ready = 1'b1;
    bus.out_ready      = 1'b1;
    repeat (20) next_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
